// File: rtl/kgp_ctrl_pkg.sv
// Shared control-block definitions: sequencer state encoding and default timeouts.
package kgp_ctrl_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_IWAIT  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } seq_state_t;

  function automatic logic is_wait_state(seq_state_t s);
    return (s == ST_IWAIT) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memory side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        dmem_req;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req,
    input  imem_ack, imem_data, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req,
    output imem_ack, imem_data, dmem_ack
  );
endinterface

// File: rtl/wait_timer.sv
// Acknowledge wait counter: expired flags the cycle on which the count would reach LIMIT.
module wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (tick)      count <= count + 1'b1;
  end

  // Combinational so an ack in the same cycle (tick low) always beats the timeout.
  assign expired = tick && (count == CW'(LIMIT - 1));
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning the architectural PC.
// Optional retired-instruction counter enabled by macro PC_SEQ_RETIRE_COUNT_EN.
module pc_sequencer
  import kgp_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  pc_sequencer_if.master         mem,
  output logic [31:0]            instr,
  input  logic                   dec_is_mem,
  input  logic                   dec_is_halt,
  input  logic [31:0]            pc_next_in,
  output logic [31:0]            pc,
  output logic                   flag_en,
  output logic                   reg_write,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   fault
`ifdef PC_SEQ_RETIRE_COUNT_EN
  ,
  output logic [31:0]            retired
`endif
);
  // state  | meaning
  // FETCH  | issue fetch request
  // IWAIT  | wait for imem_ack, capture instruction
  // DECODE | branch on halt
  // EXEC   | flag capture, branch on load/store
  // MEM    | wait for dmem_ack
  // WB     | register write, pc update
  // HALT   | absorbing, halted=1
  // FAULT  | absorbing, ack timeout

  seq_state_t cur, nxt;
  logic       timer_clear, timer_tick, timer_expired;

  always_ff @(posedge clock) begin
    if (reset) cur <= ST_FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_FETCH:  nxt = ST_IWAIT;
      ST_IWAIT:  if (mem.imem_ack) nxt = ST_DECODE;
                 else if (timer_expired) nxt = ST_FAULT;
      ST_DECODE: nxt = dec_is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   nxt = dec_is_mem ? ST_MEM : ST_WB;
      ST_MEM:    if (mem.dmem_ack) nxt = ST_WB;
                 else if (timer_expired) nxt = ST_FAULT;
      ST_WB:     nxt = ST_FETCH;
      default:   nxt = cur;
    endcase
  end

  // Outputs are held low while reset is asserted, even though the state is already FETCH.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    flag_en      = 1'b0;
    reg_write    = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    if (!reset) begin
      mem.imem_req = (cur == ST_FETCH) || (cur == ST_IWAIT);
      mem.dmem_req = (cur == ST_MEM);
      flag_en      = (cur == ST_EXEC);
      reg_write    = (cur == ST_WB);
      halted       = (cur == ST_HALT);
      fault        = (cur == ST_FAULT);
    end
  end

  assign timer_clear = !is_wait_state(cur);
  assign timer_tick  = (cur == ST_IWAIT) ? !mem.imem_ack :
                       (cur == ST_MEM)   ? !mem.dmem_ack : 1'b0;

  wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (cur == ST_IWAIT && mem.imem_ack) instr <= mem.imem_data;
      if (cur == ST_WB)                    pc    <= pc_next_in;
    end
  end

  assign mem.imem_addr = pc;
  assign state         = cur;

`ifdef PC_SEQ_RETIRE_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)             retired <= '0;
    else if (cur == ST_WB) retired <= retired + 32'd1;
  end
`endif
endmodule
